tank_step_scheduler: RTL and testbench
======================================

Name: tank_step_scheduler

Overview:
Time-shares the single map-collision lookup between the four movers: tank1 move, tank2 move, bullet1 advance and bullet2 advance.
- On each game tick it captures all pending move requests and serves them one per cycle.
- The service order rotates each tick, so simultaneous contention for the same cell is resolved fairly.
- It sits between the player input/step logic and the 324-bit (18x18) map vector, and paces all movement in the game.

Parameters:
TICK_DIV, 5000000, clock cycles per game tick; legal range >= 8.
MAP_CELLS, 324, number of map cells (18x18, row-major, index = row*18+col).

Ports:
clock  in  1  system clock; the only clock.
reset  in  1  synchronous, active-high.
enable  in  1  1 = game running; 0 = pause tick generation.
req  in  4  per-requester move request; bit0 tank1, bit1 tank2, bit2 bullet1, bit3 bullet2. Level, sampled only at tick.
target0  in  10  requested destination cell, tank1.
target1  in  10  requested destination cell, tank2.
target2  in  10  requested destination cell, bullet1.
target3  in  10  requested destination cell, bullet2.
map  in  324  wall bitmap; 1 = occupied.
tick  out  1  one-cycle pulse at each game tick.
busy  out  1  high while a scan is in progress.
grant  out  4  one-hot, one-cycle pulse: the requester being served this cycle.
grant_ok  out  1  valid with grant; 1 = move permitted, 0 = blocked.
frame_done  out  1  one-cycle pulse after the last slot of a scan.
rr_ptr  out  2  index of the requester served first in the next scan.

Behaviour:
- Reset (synchronous): every output = 0, divider = 0, state = WAIT, capture registers cleared. A reset mid-scan aborts the scan with no further grant or frame_done.
- Divider:
  - Counts 0..TICK_DIV-1 while enable=1 and holds its value while enable=0.
  - tick=1 in the cycle the counter wraps from TICK_DIV-1 to 0.
  - Because TICK_DIV >= 8, a tick can never arrive during a scan.
- States: WAIT, SCAN, DONE.
- WAIT: on tick, capture req[3:0] and all four targets into registers, clear the accepted-target list, set slot = 0, go to SCAN.
  - Inputs that change after the capture have no effect until the next tick.
- SCAN: exactly 4 cycles, slot 0..3. Let k = (rr_ptr + slot) mod 4.
  - If captured req[k]=1: grant[k]=1 for that cycle; otherwise grant=0 for that cycle (the slot is still consumed).
  - grant_ok = 0 if any of the following holds, else 1:
    - captured target >= MAP_CELLS;
    - map[target]=1, using the live map value in that cycle;
    - the target equals a target already granted with ok=1 earlier in this scan.
  - Each ok=1 target is appended to the accepted list.
  - busy=1 throughout SCAN.
- DONE: 1 cycle. frame_done=1, busy=0, rr_ptr <= rr_ptr+1 (wraps 3->0), then go to WAIT.
- Timing: tick in cycle T; slots in T+1..T+4; frame_done in T+5.
- enable falling during SCAN: the scan completes normally; only the next tick is suppressed.
- Two requesters with equal targets: the one earlier in rotation order gets ok=1 and the later one gets ok=0. Bullet and tank targets are treated identically.
- req=0000 at tick: the scan still runs, with no grants; frame_done still pulses and rr_ptr still advances.

Decomposition:
- Shared package tank_pkg holds:
  - MAP_W=18, MAP_CELLS=324, CELL_W=10;
  - requester indices REQ_TANK1=0, REQ_TANK2=1, REQ_BUL1=2, REQ_BUL2=3;
  - the scheduler state encoding.
- One sub-module, game_tick_gen: the TICK_DIV divider with enable, producing the tick pulse.
- The scheduler FSM, capture registers and accepted-target comparators stay in tank_step_scheduler.

Test Plan:
1. Tick timing: TICK_DIV=10, enable=1 from reset release -> tick pulses every 10 cycles, first tick 10 cycles after reset; rr_ptr = 0,1,2,3,0 across five scans.
2. Basic grant: rr_ptr=0, req=0101, target0=19, target2=40, map all zero except bit 40 -> grant=0001 ok=1 at T+1; grant=0100 ok=0 at T+3; frame_done at T+5.
3. Contention fairness: req=0011, target0=target1=100, map clear:
   - scan with rr_ptr=0 -> tank1 ok=1, tank2 ok=0;
   - next scan (rr_ptr=1) -> tank2 ok=1, tank1 ok=0.
4. Range and capture: target3=324, req=1000 -> grant=1000 ok=0. Changing target0 to 50 during SCAN does not alter that scan's results.
5. Pause: drop enable at T+2 -> the scan completes (frame_done at T+5); no tick while enable=0; the divider resumes from its held value when enable returns.
6. Reset mid-scan: assert reset at T+2 -> from the next cycle grant=0, busy=0, rr_ptr=0, no frame_done; the next tick occurs TICK_DIV cycles after reset release.

Source files
------------

// File: rtl/tank_pkg.sv
// Shared constants and state encoding for the tank game movement scheduler.
// Map is 18x18, row-major, one occupancy bit per cell.
package tank_pkg;

    localparam int MAP_W     = 18;
    localparam int MAP_CELLS = 324;
    localparam int CELL_W    = 10;

    localparam int REQ_TANK1 = 0;
    localparam int REQ_TANK2 = 1;
    localparam int REQ_BUL1  = 2;
    localparam int REQ_BUL2  = 3;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } sched_state_t;

endpackage

// File: rtl/game_tick_gen.sv
// Game tick divider: one-cycle pulse every TICK_DIV enabled cycles.
// The count holds while disabled, so a pause shortens nothing.
module game_tick_gen #(
    parameter int TICK_DIV = 5000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_tick;
    logic          w_wrap;

    assign w_wrap = i_en && (r_cnt == LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_wrap;
            if (w_wrap)
                r_cnt <= '0;
            else if (i_en)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/tank_step_scheduler.sv
// Serialises the four movers' collision lookups into a 4-slot scan per tick,
// rotating the first-served requester each scan for fairness.
module tank_step_scheduler
    import tank_pkg::*;
#(
    parameter int TICK_DIV = 5000000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [3:0]           req,
    input  logic [CELL_W-1:0]    target0,
    input  logic [CELL_W-1:0]    target1,
    input  logic [CELL_W-1:0]    target2,
    input  logic [CELL_W-1:0]    target3,
    input  logic [MAP_CELLS-1:0] map,
    output logic                 tick,
    output logic                 busy,
    output logic [3:0]           grant,
    output logic                 grant_ok,
    output logic                 frame_done,
    output logic [1:0]           rr_ptr
);

    sched_state_t r_state, w_next;

    logic [1:0]        r_slot;
    logic [1:0]        r_rr;
    logic [3:0]        r_req;
    logic [CELL_W-1:0] r_tgt   [4];
    logic [3:0]        r_acc_v;
    logic [CELL_W-1:0] r_acc_t [4];

    logic                 w_tick;
    logic [1:0]           w_k;
    logic [CELL_W-1:0]    w_tgt;
    logic [MAP_CELLS-1:0] w_cell;
    logic                 w_wall;
    logic                 w_dup;
    logic                 w_ok;
    logic                 w_gnt;

    game_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .i_clk (clock),
        .i_rst (reset),
        .i_en  (enable),
        .o_tick(w_tick)
    );

    // Out-of-range targets shift the one-hot cell mask to zero.
    always_comb begin
        w_k    = r_rr + r_slot;
        w_tgt  = r_tgt[w_k];
        w_cell = {{(MAP_CELLS-1){1'b0}}, 1'b1} << w_tgt;
        w_wall = |(map & w_cell);
        w_dup  = 1'b0;
        for (int j = 0; j < 4; j++)
            if (r_acc_v[j] && (r_acc_t[j] == w_tgt))
                w_dup = 1'b1;
        w_ok  = (w_tgt < CELL_W'(MAP_CELLS)) && !w_wall && !w_dup;
        w_gnt = (r_state == ST_SCAN) && r_req[w_k];
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_WAIT: if (w_tick) w_next = ST_SCAN;
            ST_SCAN: if (r_slot == 2'd3) w_next = ST_DONE;
            ST_DONE: w_next = ST_WAIT;
            default: w_next = ST_WAIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_WAIT;
            r_slot  <= 2'd0;
            r_rr    <= 2'd0;
            r_req   <= 4'd0;
            r_acc_v <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                r_tgt[i]   <= '0;
                r_acc_t[i] <= '0;
            end
        end else begin
            r_state <= w_next;
            unique case (r_state)
                ST_WAIT: if (w_tick) begin
                    r_req    <= req;
                    r_tgt[0] <= target0;
                    r_tgt[1] <= target1;
                    r_tgt[2] <= target2;
                    r_tgt[3] <= target3;
                    r_acc_v  <= 4'd0;
                    r_slot   <= 2'd0;
                end
                ST_SCAN: begin
                    r_slot <= r_slot + 1'b1;
                    if (w_gnt && w_ok) begin
                        r_acc_v[r_slot] <= 1'b1;
                        r_acc_t[r_slot] <= w_tgt;
                    end
                end
                ST_DONE: r_rr <= r_rr + 1'b1;
                default: ;
            endcase
        end
    end

    assign tick       = w_tick;
    assign busy       = (r_state == ST_SCAN);
    assign grant      = w_gnt ? (4'b0001 << w_k) : 4'b0000;
    assign grant_ok   = w_gnt && w_ok;
    assign frame_done = (r_state == ST_DONE);
    assign rr_ptr     = r_rr;

endmodule

// File: tb/tb_tank_step_scheduler.sv
// Scoreboard bench for tank_step_scheduler with a short tick period.
// Expected grant/frame_done events are queued by cycle and popped by a monitor.
module tb_tank_step_scheduler;

    localparam int TD = 10;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic [3:0]   req = 4'd0;
    logic [9:0]   target0 = '0;
    logic [9:0]   target1 = '0;
    logic [9:0]   target2 = '0;
    logic [9:0]   target3 = '0;
    logic [323:0] map = '0;
    logic         tick, busy, grant_ok, frame_done;
    logic [3:0]   grant;
    logic [1:0]   rr_ptr;

    tank_step_scheduler #(.TICK_DIV(TD)) dut (
        .clock(clock), .reset(reset), .enable(enable), .req(req),
        .target0(target0), .target1(target1),
        .target2(target2), .target3(target3), .map(map),
        .tick(tick), .busy(busy), .grant(grant), .grant_ok(grant_ok),
        .frame_done(frame_done), .rr_ptr(rr_ptr)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [3:0] g;
        logic       ok;
        logic       fd;
        logic [1:0] rr;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic push_g(input int c, input logic [3:0] g, input logic ok);
        q.push_back('{c: c, g: g, ok: ok, fd: 1'b0, rr: 2'd0});
    endtask

    task automatic push_fd(input int c, input logic [1:0] rr);
        q.push_back('{c: c, g: 4'd0, ok: 1'b0, fd: 1'b1, rr: rr});
    endtask

    task automatic wait_tick(output int t);
        t = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (tick) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL tick_timeout: got none expected tick (cycle %0d)", cyc);
        end
    endtask

    always @(negedge clock) begin
        if (grant != 4'd0 || frame_done || grant_ok) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_evt: got grant=%b ok=%b fd=%b expected none (cycle %0d)",
                         grant, grant_ok, frame_done, cyc);
            end else begin
                e = q.pop_front();
                chk("evt_cycle", cyc, e.c);
                chk("evt_grant", {28'd0, grant}, {28'd0, e.g});
                chk("evt_ok", {31'd0, grant_ok}, {31'd0, e.ok});
                chk("evt_fd", {31'd0, frame_done}, {31'd0, e.fd});
                if (e.fd) chk("evt_rr", {30'd0, rr_ptr}, {30'd0, e.rr});
            end
        end
    end

    int t, tp, rel, p, nt;

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_tick", {31'd0, tick}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_grant", {28'd0, grant}, 0);
        chk("rst_fd", {31'd0, frame_done}, 0);
        chk("rst_rr", {30'd0, rr_ptr}, 0);

        // scan 0, rr=0: basic grant, bullet1 blocked by wall
        enable = 1'b1;
        req = 4'b0101; target0 = 10'd19; target2 = 10'd40; map[40] = 1'b1;
        rel = cyc;
        reset = 1'b0;
        wait_tick(t);
        chk("tick_first", t, rel + TD);
        push_g(t + 1, 4'b0001, 1'b1);
        push_g(t + 3, 4'b0100, 1'b0);
        push_fd(t + 5, 2'd0);
        @(negedge clock);
        chk("busy_scan", {31'd0, busy}, 1);
        repeat (5) @(negedge clock);
        chk("rr_after0", {30'd0, rr_ptr}, 1);
        chk("busy_idle", {31'd0, busy}, 0);

        // scan 1, rr=1: contention, tank2 first
        req = 4'b0011; target0 = 10'd100; target1 = 10'd100; map = '0;
        tp = t;
        wait_tick(t);
        chk("tick_period1", t, tp + TD);
        push_g(t + 1, 4'b0010, 1'b1);
        push_g(t + 4, 4'b0001, 1'b0);
        push_fd(t + 5, 2'd1);
        repeat (6) @(negedge clock);
        chk("rr_after1", {30'd0, rr_ptr}, 2);

        // scan 2, rr=2: out-of-range bullet2, capture isolation for tank1
        req = 4'b1001; target3 = 10'd324; target0 = 10'd60;
        tp = t;
        wait_tick(t);
        chk("tick_period2", t, tp + TD);
        push_g(t + 2, 4'b1000, 1'b0);
        push_g(t + 3, 4'b0001, 1'b1);
        push_fd(t + 5, 2'd2);
        @(negedge clock);
        target0 = 10'd50; map[50] = 1'b1;
        repeat (5) @(negedge clock);
        chk("rr_after2", {30'd0, rr_ptr}, 3);

        // scan 3, rr=3: no requests
        req = 4'b0000; map = '0;
        wait_tick(t);
        push_fd(t + 5, 2'd3);
        repeat (6) @(negedge clock);
        chk("rr_wrap", {30'd0, rr_ptr}, 0);

        // scan 4, rr=0: three-way contention incl. bullet
        req = 4'b0111; target0 = 10'd100; target1 = 10'd100; target2 = 10'd100;
        wait_tick(t);
        push_g(t + 1, 4'b0001, 1'b1);
        push_g(t + 2, 4'b0010, 1'b0);
        push_g(t + 3, 4'b0100, 1'b0);
        push_fd(t + 5, 2'd0);
        repeat (6) @(negedge clock);
        chk("rr_after4", {30'd0, rr_ptr}, 1);

        // scan 5, rr=1: pause mid-scan, divider holds at 2
        req = 4'b0001; target0 = 10'd5;
        wait_tick(t);
        push_g(t + 4, 4'b0001, 1'b1);
        push_fd(t + 5, 2'd1);
        repeat (2) @(negedge clock);
        enable = 1'b0;
        repeat (4) @(negedge clock);
        chk("rr_after5", {30'd0, rr_ptr}, 2);
        nt = 0;
        repeat (30) begin
            @(negedge clock);
            if (tick) nt++;
        end
        chk("paused_ticks", nt, 0);
        req = 4'b0001; target0 = 10'd7;
        p = cyc;
        enable = 1'b1;
        wait_tick(t);
        chk("tick_resume", t, p + 8);

        // scan 6, rr=2: reset at T+2 aborts before tank1's slot
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("rstmid_grant", {28'd0, grant}, 0);
        chk("rstmid_busy", {31'd0, busy}, 0);
        chk("rstmid_rr", {30'd0, rr_ptr}, 0);
        chk("rstmid_fd", {31'd0, frame_done}, 0);
        @(negedge clock);
        rel = cyc;
        reset = 1'b0;
        wait_tick(t);
        chk("tick_after_rst", t, rel + TD);

        // scan 7, rr=0 again after reset
        push_g(t + 1, 4'b0001, 1'b1);
        push_fd(t + 5, 2'd0);
        repeat (6) @(negedge clock);
        chk("queue_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
